// File: rtl/event_monitor_pkg.sv
// Shared definitions for the event-monitor drain engine: FSM state encoding,
// default register map of the monitor's register port and small state helpers.
package event_monitor_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ST_RD,
    ST_CAP,
    WAIT,
    D_RD,
    D_CAP,
    I_RD,
    I_CAP,
    T_RD,
    T_CAP,
    POP,
    OUT
  } drain_state_e;

  localparam logic [7:0]  STATUS_ADDR_DEF  = 8'h10;
  localparam logic [7:0]  DATA_ADDR_DEF    = 8'h20;
  localparam logic [7:0]  ID_ADDR_DEF      = 8'h24;
  localparam logic [7:0]  TS_ADDR_DEF      = 8'h28;
  localparam logic [7:0]  POP_ADDR_DEF     = 8'h2C;
  localparam int          STATUS_AVAIL_BIT = 0;
  localparam logic [31:0] POP_CMD          = 32'h1;

  // The engine counts as busy whenever it owns an event or a poll is in flight.
  function automatic logic state_is_busy(input drain_state_e s);
    return !((s == IDLE) || (s == WAIT));
  endfunction

  // States in which a read strobe is on the bus.
  function automatic logic state_is_read(input drain_state_e s);
    return (s == ST_RD) || (s == D_RD) || (s == I_RD) || (s == T_RD);
  endfunction

endpackage

// File: rtl/event_monitor_drain.sv
// Drain engine for the event monitor: polls STATUS over the simple register
// bus, reads the head event's data/id/timestamp words, pops it, and offers the
// assembled {ts, id, data} record on a valid/ready stream.
module event_monitor_drain
  import event_monitor_pkg::*;
#(
  parameter int         PROBE_W     = 32,
  parameter int         ID_W        = 8,
  parameter int         TS_W        = 32,
  parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [7:0] DATA_ADDR   = DATA_ADDR_DEF,
  parameter logic [7:0] ID_ADDR     = ID_ADDR_DEF,
  parameter logic [7:0] TS_ADDR     = TS_ADDR_DEF,
  parameter logic [7:0] POP_ADDR    = POP_ADDR_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [15:0]                   poll_interval,
  output logic                          bus_wr,
  output logic                          bus_rd,
  output logic [7:0]                    bus_addr,
  output logic [31:0]                   bus_wdata,
  input  logic [31:0]                   bus_rdata,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [TS_W+ID_W+PROBE_W-1:0]  rec_data,
  output logic [31:0]                   rec_count,
  output logic                          busy
);

  localparam int REC_W = TS_W + ID_W + PROBE_W;

  drain_state_e        state_q, state_d;
  logic [15:0]         timer_q, timer_d;
  logic                bus_wr_q, bus_rd_q;
  logic [7:0]          bus_addr_q, bus_addr_d;
  logic [31:0]         bus_wdata_q;
  logic                rec_valid_q;
  logic [REC_W-1:0]    rec_data_q;
  logic [31:0]         rec_count_q;
  logic                busy_q;

  // Next-state and poll-timer logic; one state per cycle except WAIT and OUT.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:   if (en) state_d = ST_RD;
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        if (bus_rdata[STATUS_AVAIL_BIT]) begin
          state_d = D_RD;
        end else begin
          state_d = WAIT;
          timer_d = poll_interval;
        end
      end
      WAIT: begin
        if (timer_q == 16'd0) state_d = en ? ST_RD : IDLE;
        else                  timer_d = timer_q - 16'd1;
      end
      D_RD:   state_d = D_CAP;
      D_CAP:  state_d = I_RD;
      I_RD:   state_d = I_CAP;
      I_CAP:  state_d = T_RD;
      T_RD:   state_d = T_CAP;
      T_CAP:  state_d = POP;
      POP:    state_d = OUT;
      OUT:    if (rec_ready) state_d = en ? ST_RD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address for the access launched on entry to the next state; held otherwise
  // so addr stays stable around each strobe.
  always_comb begin
    bus_addr_d = bus_addr_q;
    case (state_d)
      ST_RD:   bus_addr_d = STATUS_ADDR;
      D_RD:    bus_addr_d = DATA_ADDR;
      I_RD:    bus_addr_d = ID_ADDR;
      T_RD:    bus_addr_d = TS_ADDR;
      POP:     bus_addr_d = POP_ADDR;
      default: bus_addr_d = bus_addr_q;
    endcase
  end

  // FSM register with registered bus strobes, record capture and delivery count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_addr_q  <= 8'd0;
      bus_wdata_q <= 32'd0;
      rec_valid_q <= 1'b0;
      rec_data_q  <= '0;
      rec_count_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      busy_q     <= state_is_busy(state_d);
      bus_rd_q   <= state_is_read(state_d);
      bus_wr_q   <= (state_d == POP);
      bus_addr_q <= bus_addr_d;
      if (state_d == POP) bus_wdata_q <= POP_CMD;

      // Read data arrives the cycle after the strobe, i.e. in the *_CAP state.
      case (state_q)
        D_CAP:   rec_data_q[PROBE_W-1:0]          <= bus_rdata[PROBE_W-1:0];
        I_CAP:   rec_data_q[PROBE_W +: ID_W]      <= bus_rdata[ID_W-1:0];
        T_CAP:   rec_data_q[PROBE_W+ID_W +: TS_W] <= bus_rdata[TS_W-1:0];
        default: ;
      endcase

      rec_valid_q <= (state_d == OUT);
      if (rec_valid_q && rec_ready) rec_count_q <= rec_count_q + 32'd1;
    end
  end

  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rec_valid = rec_valid_q;
  assign rec_data  = rec_data_q;
  assign rec_count = rec_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_event_monitor_drain.sv
// Bench for event_monitor_drain: a behavioural event-monitor FIFO answers the
// register bus, and an expected-record queue checks every delivered record.
module tb_event_monitor_drain;

  localparam int RW = 72;
  localparam logic [7:0] A_STATUS = 8'h10;
  localparam logic [7:0] A_DATA   = 8'h20;
  localparam logic [7:0] A_ID     = 8'h24;
  localparam logic [7:0] A_TS     = 8'h28;
  localparam logic [7:0] A_POP    = 8'h2C;

  logic          clk, rst_n, en, rec_ready;
  logic [15:0]   poll_interval;
  logic          bus_wr, bus_rd, rec_valid, busy;
  logic [7:0]    bus_addr;
  logic [31:0]   bus_wdata, bus_rdata, rec_count;
  logic [RW-1:0] rec_data;

  event_monitor_drain dut (
    .clk(clk), .rst_n(rst_n), .en(en), .poll_interval(poll_interval),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .rec_count(rec_count), .busy(busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] idw;
    logic [31:0] ts;
  } ev_t;

  ev_t           fifo_q[$];
  logic [RW-1:0] exp_q[$];
  int            status_rd_q[$];
  int            hs_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_pop = 0;
  int hs_total = 0;
  int hit_cyc = -100;
  logic [31:0]   model_cnt = 0;
  logic          prev_valid = 0, prev_ready = 0, prev_status_rd = 0;
  logic [RW-1:0] prev_data = '0, last_rec = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_event(input logic [31:0] d, input logic [7:0] id, input logic [31:0] ts);
    ev_t e;
    logic [31:0] w;
    w = $urandom();
    w[7:0] = id;
    e.d = d; e.idw = w; e.ts = ts;
    fifo_q.push_back(e);
    exp_q.push_back({ts, id, d});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int i = 0;
    while (hs_total < target && i < budget) begin step(); i++; end
    check(tag, hs_total >= target, 1'b1);
  endtask

  // Behavioural monitor FIFO behind the register port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= 32'd0;
    end else begin
      if (bus_rd) begin
        case (bus_addr)
          A_STATUS: bus_rdata <= ($urandom() & 32'hFFFF_FFFE) | {31'd0, fifo_q.size() != 0};
          A_DATA:   bus_rdata <= (fifo_q.size() != 0) ? fifo_q[0].d   : 32'hBAD0_0D00;
          A_ID:     bus_rdata <= (fifo_q.size() != 0) ? fifo_q[0].idw : 32'hBAD0_1D00;
          A_TS:     bus_rdata <= (fifo_q.size() != 0) ? fifo_q[0].ts  : 32'hBAD0_7500;
          default:  bus_rdata <= 32'hFFFF_FFFF;
        endcase
      end
      if (bus_wr && bus_addr == A_POP && bus_wdata == 32'h1) begin
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        n_pop++;
      end
    end
  end

  // Protocol watcher and record scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_rd) n_rd++;
      if (bus_wr) n_wr++;
      if (bus_rd || bus_wr) check("rd_wr_exclusive", bus_rd && bus_wr, 1'b0);
      if (bus_wr) begin
        check("pop_addr", bus_addr, A_POP);
        check("pop_wdata", bus_wdata, 32'h1);
        check("pop_nonempty", fifo_q.size() != 0, 1'b1);
      end
      if (prev_status_rd && bus_rdata[0]) hit_cyc = cyc;
      prev_status_rd = bus_rd && (bus_addr == A_STATUS);
      if (prev_status_rd) status_rd_q.push_back(cyc);
      if (rec_valid && !prev_valid) check("hit_to_valid", cyc - hit_cyc, 8);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", rec_valid, 1'b1);
        check("hold_data", rec_data, prev_data);
      end
      if (rec_valid) check("quiet_while_valid", bus_rd || bus_wr, 1'b0);
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) check("rec_unexpected", 1'b1, 1'b0);
        else begin
          check("rec_data", rec_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        check("rec_count_track", rec_count, model_cnt);
        model_cnt = model_cnt + 1;
        last_rec = rec_data;
        hs_q.push_back(cyc);
        hs_total++;
      end
      prev_valid = rec_valid;
      prev_ready = rec_ready;
      prev_data  = rec_data;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_status_rd = 1'b0;
      model_cnt = 0;
      hit_cyc = -100;
    end
  end

  initial begin
    int p0, h0, w0, r0, s0, nxt, i;
    rst_n = 1'b0; en = 1'b0; rec_ready = 1'b0; poll_interval = 16'd5;
    repeat (3) step();

    // Reset values
    check("rst_bus_rd", bus_rd, 1'b0);
    check("rst_bus_wr", bus_wr, 1'b0);
    check("rst_bus_addr", bus_addr, 8'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rec_valid", rec_valid, 1'b0);
    check("rst_rec_data", rec_data, '0);
    check("rst_rec_count", rec_count, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_busy", busy, 1'b0);
    check("idle_no_rd", n_rd, 0);

    // Empty polling cadence
    en = 1'b1;
    repeat (4) step();
    status_rd_q.delete();
    w0 = n_wr;
    i = 0;
    while (status_rd_q.size() < 4 && i < 200) begin step(); i++; end
    check("poll_seen", status_rd_q.size() >= 4, 1'b1);
    for (int k = 1; k < status_rd_q.size() && k < 4; k++)
      check("poll_period", status_rd_q[k] - status_rd_q[k-1], 8);
    check("poll_no_wr", n_wr - w0, 0);

    // Single known event
    rec_ready = 1'b1;
    p0 = n_pop;
    push_event(32'hDEAD_BEEF, 8'h5A, 32'h0000_1234);
    wait_hs(1, 200, "t3_timeout");
    check("t3_rec", last_rec, 72'h0000_1234_5A_DEAD_BEEF);
    check("t3_pops", n_pop - p0, 1);
    check("t3_count", rec_count, 32'd1);

    // Three back-to-back events
    p0 = n_pop; h0 = hs_total;
    status_rd_q.delete();
    for (int k = 0; k < 3; k++) push_event($urandom(), 8'($urandom()), $urandom());
    wait_hs(h0 + 3, 400, "t4_timeout");
    repeat (2) step();
    if (hs_q.size() >= h0 + 3) begin
      check("t4_gap1", hs_q[h0+1] - hs_q[h0], 10);
      check("t4_gap2", hs_q[h0+2] - hs_q[h0+1], 10);
      nxt = -1;
      foreach (status_rd_q[k]) if (nxt < 0 && status_rd_q[k] > hs_q[h0+2]) nxt = status_rd_q[k];
      check("t4_next_poll", nxt - hs_q[h0+2], 1);
    end
    check("t4_pops", n_pop - p0, 3);
    check("t4_count", rec_count, 32'd4);

    // Sink stall in OUT
    rec_ready = 1'b0;
    p0 = n_pop;
    push_event($urandom(), 8'($urandom()), $urandom());
    i = 0;
    while (!rec_valid && i < 200) begin step(); i++; end
    check("t5_valid_seen", rec_valid, 1'b1);
    check("t5_popped_early", n_pop - p0, 1);
    s0 = n_rd + n_wr;
    repeat (20) step();
    check("t5_still_valid", rec_valid, 1'b1);
    check("t5_no_strobes", (n_rd + n_wr) - s0, 0);
    rec_ready = 1'b1;
    wait_hs(hs_total + 1, 20, "t5_timeout");

    // Randomised stream with random sink back-pressure
    poll_interval = 16'($urandom_range(0, 3));
    h0 = hs_total;
    for (int k = 0; k < 6; k++) push_event($urandom(), 8'($urandom()), $urandom());
    i = 0;
    while (hs_total < h0 + 6 && i < 3000) begin
      rec_ready = 1'($urandom_range(0, 1));
      step(); i++;
    end
    check("rand_done", hs_total >= h0 + 6, 1'b1);
    check("rand_exp_empty", exp_q.size(), 0);
    rec_ready = 1'b1;
    poll_interval = 16'd5;
    repeat (12) step();

    // en dropped during I_RD
    h0 = hs_total;
    push_event($urandom(), 8'($urandom()), $urandom());
    push_event($urandom(), 8'($urandom()), $urandom());
    i = 0;
    while (!(bus_rd && bus_addr == A_ID) && i < 200) begin step(); i++; end
    check("t6_id_rd_seen", bus_rd && bus_addr == A_ID, 1'b1);
    en = 1'b0;
    wait_hs(h0 + 1, 100, "t6_timeout");
    repeat (2) step();
    check("t6_busy_low", busy, 1'b0);
    r0 = n_rd;
    repeat (30) step();
    check("t6_no_rd", n_rd - r0, 0);
    check("t6_fifo_left", fifo_q.size(), 1);

    // Async reset in T_CAP, event must survive
    en = 1'b1;
    i = 0;
    while (!(bus_rd && bus_addr == A_TS) && i < 200) begin step(); i++; end
    check("t7_ts_rd_seen", bus_rd && bus_addr == A_TS, 1'b1);
    p0 = n_pop;
    step();
    rst_n = 1'b0;
    #1;
    check("t7_rst_bus_rd", bus_rd, 1'b0);
    check("t7_rst_bus_wr", bus_wr, 1'b0);
    check("t7_rst_addr", bus_addr, 8'h0);
    check("t7_rst_wdata", bus_wdata, 32'h0);
    check("t7_rst_valid", rec_valid, 1'b0);
    check("t7_rst_data", rec_data, '0);
    check("t7_rst_count", rec_count, 32'h0);
    check("t7_rst_busy", busy, 1'b0);
    step();
    check("t7_no_pop", n_pop - p0, 0);
    check("t7_fifo_kept", fifo_q.size(), 1);
    rst_n = 1'b1;
    h0 = hs_total;
    wait_hs(h0 + 1, 200, "t7_timeout");
    check("t7_count", rec_count, 32'd1);
    check("t7_pop", n_pop - p0, 1);
    check("t7_fifo_empty", fifo_q.size(), 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
